list_walker: RTL

//  Pointer-chasing read engine between the eval core and memory's read port (req/addr_in/data_ready/data_out).

---
 rtl/list_walker_pkg.sv | 33 +++
 rtl/list_walker_if.sv | 32 +++
 rtl/list_walker.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/list_walker_pkg.sv
// list_walker_pkg: shared tagged-word constants, walk op encoding and decode helpers.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
// Tagged word layout: [15] unused by the walker, [14:12] type tag, [11:0] heap address.
package list_walker_pkg;

  localparam logic [2:0]  TYPE_CONS = 3'd1;
  localparam logic [15:0] LISP_NIL  = 16'h0000;

  typedef enum logic [1:0] {
    OP_CAR = 2'd0,
    OP_CDR = 2'd1,
    OP_NTH = 2'd2,
    OP_LEN = 2'd3
  } walk_op_t;

  function automatic logic [2:0] ptr_type(input logic [15:0] w);
    return w[14:12];
  endfunction

  function automatic logic [11:0] ptr_addr(input logic [15:0] w);
    return w[11:0];
  endfunction

  function automatic logic is_nil(input logic [15:0] w);
    return w == LISP_NIL;
  endfunction

  function automatic logic is_cons(input logic [15:0] w);
    return ptr_type(w) == TYPE_CONS;
  endfunction

endpackage

// File: rtl/list_walker_if.sv
// list_walker_if: eval-core start/done handshake plus the single-word memory read port.
// Latency: n/a (wires only).
// Backpressure: start is only accepted while busy is low; memory answers with data_ready.
// Ports (slave = walker side): start/op/ptr_in/index in, busy/done/result/error out,
// mem_req/mem_addr out, mem_data_ready/mem_data_in in. master is the mirror image.
interface list_walker_if;
  import list_walker_pkg::*;

  logic        start;
  walk_op_t    op;
  logic [15:0] ptr_in;
  logic [11:0] index;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic        error;
  logic        mem_req;
  logic [11:0] mem_addr;
  logic        mem_data_ready;
  logic [15:0] mem_data_in;

  modport slave (
    input  start, op, ptr_in, index, mem_data_ready, mem_data_in,
    output busy, done, result, error, mem_req, mem_addr
  );

  modport master (
    output start, op, ptr_in, index, mem_data_ready, mem_data_in,
    input  busy, done, result, error, mem_req, mem_addr
  );

endinterface

// File: rtl/list_walker.sv
// list_walker: pointer-chasing CAR/CDR/NTH/LENGTH engine issuing single-word heap reads.
// Latency: nil/atom decided in 2 cycles, CAR/CDR on a cons in 4, +3 per cdr hop (+memory wait).
// Backpressure: one op at a time; start ignored while busy; waits indefinitely on data_ready.
// Ports: clk, rst (sync, active-high), bus (list_walker_if.slave: core handshake + memory port).
// Parameter MaxSteps bounds cdr hops per op so a cyclic list terminates with error.
module list_walker
  import list_walker_pkg::*;
#(
  parameter int unsigned MaxSteps = 4095
) (
  input  logic          clk,
  input  logic          rst,
  list_walker_if.slave  bus
);

  localparam logic [11:0] MAX_STEPS = 12'(MaxSteps);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_READ,
    ST_WAIT,
    ST_DONE
  } walk_state_t;

  walk_state_t state, state_d;
  walk_op_t    op_q, op_d;
  logic [11:0] index_q, index_d;
  logic [15:0] cur, cur_d;
  logic [11:0] count, count_d;
  logic [11:0] steps, steps_d;
  logic [15:0] result_q, result_d;
  logic        error_q, error_d;
  logic [11:0] mem_addr_q, mem_addr_d;
  logic        rd_cdr, rd_cdr_d;   // outstanding read targets a cdr slot (else a car)

  // Check-state decision helpers
  logic        go_read;
  logic        go_cdr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      op_q       <= OP_CAR;
      index_q    <= '0;
      cur        <= '0;
      count      <= '0;
      steps      <= '0;
      result_q   <= '0;
      error_q    <= 1'b0;
      mem_addr_q <= '0;
      rd_cdr     <= 1'b0;
    end else begin
      state      <= state_d;
      op_q       <= op_d;
      index_q    <= index_d;
      cur        <= cur_d;
      count      <= count_d;
      steps      <= steps_d;
      result_q   <= result_d;
      error_q    <= error_d;
      mem_addr_q <= mem_addr_d;
      rd_cdr     <= rd_cdr_d;
    end
  end

  always_comb begin
    state_d    = state;
    op_d       = op_q;
    index_d    = index_q;
    cur_d      = cur;
    count_d    = count;
    steps_d    = steps;
    result_d   = result_q;
    error_d    = error_q;
    mem_addr_d = mem_addr_q;
    rd_cdr_d   = rd_cdr;
    go_read    = 1'b0;
    go_cdr     = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (bus.start) begin
          op_d    = bus.op;
          index_d = bus.index;
          cur_d   = bus.ptr_in;
          count_d = '0;
          steps_d = '0;
          state_d = ST_CHECK;
        end
      end

      ST_CHECK: begin
        if (is_nil(cur)) begin
          // NTH past the end is a normal nil, not an error
          result_d = (op_q == OP_LEN) ? {4'h0, count} : LISP_NIL;
          error_d  = 1'b0;
          state_d  = ST_DONE;
        end else if (is_cons(cur) && steps != MAX_STEPS) begin
          unique case (op_q)
            OP_CAR: go_read = 1'b1;
            OP_CDR: begin go_read = 1'b1; go_cdr = 1'b1; end
            OP_NTH: begin
              if (count == index_q) begin
                go_read = 1'b1;
              end else if (count < index_q) begin
                go_read = 1'b1;
                go_cdr  = 1'b1;
              end
            end
            OP_LEN: begin go_read = 1'b1; go_cdr = 1'b1; end
            default: ;
          endcase
          if (!go_read) begin
            result_d = cur;
            error_d  = 1'b1;
            state_d  = ST_DONE;
          end
        end else begin
          // improper atom, or hop budget exhausted on a cons
          result_d = cur;
          error_d  = 1'b1;
          state_d  = ST_DONE;
        end

        if (go_read) begin
          // cdr slot sits one word below the car; wraps modulo 4096
          mem_addr_d = go_cdr ? ptr_addr(cur) - 12'd1 : ptr_addr(cur);
          rd_cdr_d   = go_cdr;
          state_d    = ST_READ;
        end
      end

      ST_READ: begin
        if (rd_cdr) steps_d = steps + 12'd1;
        state_d = ST_WAIT;
      end

      ST_WAIT: begin
        if (bus.mem_data_ready) begin
          if (!rd_cdr) begin
            result_d = bus.mem_data_in;
            error_d  = 1'b0;
            state_d  = ST_DONE;
          end else begin
            cur_d   = bus.mem_data_in;
            count_d = count + 12'd1;
            if (op_q == OP_CDR) begin
              result_d = bus.mem_data_in;
              error_d  = 1'b0;
              state_d  = ST_DONE;
            end else begin
              state_d = ST_CHECK;
            end
          end
        end
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.busy     = (state != ST_IDLE);
  assign bus.done     = (state == ST_DONE);
  assign bus.mem_req  = (state == ST_READ);
  assign bus.mem_addr = mem_addr_q;
  assign bus.result   = result_q;
  assign bus.error    = error_q;

endmodule
